// File: rtl/time_entry_register.sv
// time_entry_register
//   Receives BCD digits from the keypad encoder and shifts accepted digits
//   right-to-left into a three-digit M:SS entry register.
//
//   Parameters:
//     MIN_LOW      consecutive low cycles of loadn needed to accept a press (1..15)
//   Ports:
//     clock        system clock, rising edge
//     clrn         asynchronous active-low reset
//     clr          synchronous entry clear
//     lock         high while magnetron runs; presses ignored
//     data         BCD digit, valid while loadn is low
//     loadn        active-low digit strobe, held for the whole press
//     sec_ones     entered seconds-ones digit
//     sec_tens     entered seconds-tens digit
//     mins         entered minutes digit
//     count        digits accepted since last clear (0..3)
//     digit_strobe one-cycle pulse after a digit is accepted
//     reject       one-cycle pulse after a press is refused
//     entry_valid  count != 0 and sec_tens <= 5
module time_entry_register #(
  parameter int unsigned MIN_LOW = 2
) (
  input  logic       clock,
  input  logic       clrn,
  input  logic       clr,
  input  logic       lock,
  input  logic [3:0] data,
  input  logic       loadn,
  output logic [3:0] sec_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] mins,
  output logic [1:0] count,
  output logic       digit_strobe,
  output logic       reject,
  output logic       entry_valid
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    QUAL = 2'd1,
    HELD = 2'd2
  } state_t;

  localparam logic [4:0] MIN_LOW_W = 5'(MIN_LOW);

  state_t     state, state_nxt;
  logic [3:0] low_cnt, low_cnt_nxt;
  logic       eval;

  always_ff @(posedge clock or negedge clrn) begin
    if (!clrn) begin
      state   <= IDLE;
      low_cnt <= '0;
    end else begin
      state   <= state_nxt;
      low_cnt <= low_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    low_cnt_nxt = low_cnt;
    eval        = 1'b0;
    case (state)
      IDLE: begin
        if (!loadn) begin
          low_cnt_nxt = 4'd1;
          if (MIN_LOW_W == 5'd1) begin
            eval      = 1'b1;
            state_nxt = HELD;
          end else begin
            state_nxt = QUAL;
          end
        end
      end
      QUAL: begin
        if (loadn) begin
          // released before qualification: glitch, nothing evaluated
          state_nxt   = IDLE;
          low_cnt_nxt = '0;
        end else begin
          low_cnt_nxt = low_cnt + 4'd1;
          if (({1'b0, low_cnt} + 5'd1) == MIN_LOW_W) begin
            eval      = 1'b1;
            state_nxt = HELD;
          end
        end
      end
      HELD: begin
        if (loadn) begin
          state_nxt   = IDLE;
          low_cnt_nxt = '0;
        end
      end
      default: begin
        state_nxt   = IDLE;
        low_cnt_nxt = '0;
      end
    endcase
    // Clear aborts the press. A key still held through the clear parks in
    // HELD so it is not re-accepted; it must be released first.
    if (clr) begin
      eval        = 1'b0;
      low_cnt_nxt = '0;
      state_nxt   = loadn ? IDLE : HELD;
    end
  end

  always_ff @(posedge clock or negedge clrn) begin
    if (!clrn) begin
      sec_ones     <= '0;
      sec_tens     <= '0;
      mins         <= '0;
      count        <= '0;
      digit_strobe <= 1'b0;
      reject       <= 1'b0;
    end else begin
      digit_strobe <= 1'b0;
      reject       <= 1'b0;
      if (clr) begin
        sec_ones <= '0;
        sec_tens <= '0;
        mins     <= '0;
        count    <= '0;
      end else if (eval && !lock) begin
        if (data > 4'd9 || count == 2'd3) begin
          reject <= 1'b1;
        end else begin
          mins         <= sec_tens;
          sec_tens     <= sec_ones;
          sec_ones     <= data;
          count        <= count + 2'd1;
          digit_strobe <= 1'b1;
        end
      end
    end
  end

  assign entry_valid = (count != 2'd0) && (sec_tens <= 4'd5);

endmodule

// File: tb/tb_time_entry_register.sv
module tb_time_entry_register;

  localparam int MIN_LOW = 2;

  logic       clock = 1'b0;
  logic       clrn;
  logic       clr;
  logic       lock;
  logic [3:0] data;
  logic       loadn;
  logic [3:0] sec_ones, sec_tens, mins;
  logic [1:0] count;
  logic       digit_strobe, reject, entry_valid;

  int checks = 0;
  int errors = 0;
  int strobes_seen = 0;
  int rejects_seen = 0;

  time_entry_register #(.MIN_LOW(MIN_LOW)) dut (
    .clock        (clock),
    .clrn         (clrn),
    .clr          (clr),
    .lock         (lock),
    .data         (data),
    .loadn        (loadn),
    .sec_ones     (sec_ones),
    .sec_tens     (sec_tens),
    .mins         (mins),
    .count        (count),
    .digit_strobe (digit_strobe),
    .reject       (reject),
    .entry_valid  (entry_valid)
  );

  always #5 clock = ~clock;

  // Behavioural reference: tracks the length of the current low run and
  // whether this press has already been used up.
  int m_ones = 0, m_tens = 0, m_mins = 0, m_cnt = 0;
  int m_strobe = 0, m_reject = 0;
  int run = 0;
  bit dead = 0;

  always @(posedge clock or negedge clrn) begin
    if (!clrn) begin
      m_ones = 0; m_tens = 0; m_mins = 0; m_cnt = 0;
      m_strobe = 0; m_reject = 0; run = 0; dead = 0;
    end else begin
      m_strobe = 0;
      m_reject = 0;
      if (clr) begin
        m_ones = 0; m_tens = 0; m_mins = 0; m_cnt = 0;
        run = 0;
        dead = !loadn;
      end else if (loadn) begin
        run = 0;
        dead = 0;
      end else if (!dead) begin
        run++;
        if (run == MIN_LOW) begin
          dead = 1;
          if (!lock) begin
            if (int'(data) > 9 || m_cnt == 3) m_reject = 1;
            else begin
              m_mins = m_tens; m_tens = m_ones; m_ones = int'(data);
              m_cnt++;
              m_strobe = 1;
            end
          end
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    chk("mins", int'(mins), m_mins);
    chk("sec_tens", int'(sec_tens), m_tens);
    chk("sec_ones", int'(sec_ones), m_ones);
    chk("count", int'(count), m_cnt);
    chk("digit_strobe", int'(digit_strobe), m_strobe);
    chk("reject", int'(reject), m_reject);
    chk("entry_valid", int'(entry_valid), (m_cnt != 0 && m_tens <= 5) ? 1 : 0);
    if (digit_strobe) strobes_seen++;
    if (reject) rejects_seen++;
  end

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clock);
      #1;
    end
  endtask

  task automatic press(input logic [3:0] d, input int n);
    data = d;
    loadn = 1'b0;
    step(n);
    loadn = 1'b1;
    step(2);
  endtask

  task automatic clr_pulse();
    clr = 1'b1;
    step(1);
    clr = 1'b0;
    step(1);
  endtask

  task automatic chk_digits(input string tag, input int mi, input int te, input int on, input int cn);
    chk({tag, ".mins"}, int'(mins), mi);
    chk({tag, ".sec_tens"}, int'(sec_tens), te);
    chk({tag, ".sec_ones"}, int'(sec_ones), on);
    chk({tag, ".count"}, int'(count), cn);
  endtask

  int s0, r0;

  initial begin
    clrn = 1'b0; clr = 1'b0; lock = 1'b0; data = 4'd0; loadn = 1'b1;
    step(3);
    chk_digits("reset", 0, 0, 0, 0);
    chk("reset.entry_valid", int'(entry_valid), 0);
    clrn = 1'b1;
    step(2);

    // 1,3,0 -> 1:30
    s0 = strobes_seen;
    press(4'd1, 4); press(4'd3, 4); press(4'd0, 4);
    chk_digits("m130", 1, 3, 0, 3);
    chk("m130.entry_valid", int'(entry_valid), 1);
    chk("m130.strobes", strobes_seen - s0, 3);

    // fourth digit refused
    r0 = rejects_seen; s0 = strobes_seen;
    press(4'd9, 4);
    chk_digits("fourth", 1, 3, 0, 3);
    chk("fourth.rejects", rejects_seen - r0, 1);
    chk("fourth.strobes", strobes_seen - s0, 0);

    clr_pulse();
    chk_digits("clr", 0, 0, 0, 0);

    // glitch then a just-long-enough press
    s0 = strobes_seen;
    data = 4'd5; loadn = 1'b0; step(1); loadn = 1'b1; step(2);
    chk_digits("glitch", 0, 0, 0, 0);
    chk("glitch.strobes", strobes_seen - s0, 0);
    loadn = 1'b0; step(2); loadn = 1'b1;
    chk_digits("minlow", 0, 0, 5, 1);
    step(2);

    // illegal code
    r0 = rejects_seen;
    press(4'hC, 4);
    chk("illegal.rejects", rejects_seen - r0, 1);
    chk_digits("illegal", 0, 0, 5, 1);

    // 7,5 -> 0:75 invalid
    clr_pulse();
    press(4'd7, 4); press(4'd5, 4);
    chk_digits("m075", 0, 7, 5, 2);
    chk("m075.entry_valid", int'(entry_valid), 0);

    // locked press ignored
    s0 = strobes_seen; r0 = rejects_seen;
    lock = 1'b1; press(4'd4, 4); lock = 1'b0;
    chk_digits("lock", 0, 7, 5, 2);
    chk("lock.pulses", (strobes_seen - s0) + (rejects_seen - r0), 0);

    // long hold gives one strobe
    s0 = strobes_seen;
    press(4'd4, 20);
    chk("hold.strobes", strobes_seen - s0, 1);
    chk_digits("hold", 7, 5, 4, 3);
    chk("hold.entry_valid", int'(entry_valid), 1);

    // clr on the accept edge, key held through and past the clear
    clr_pulse();
    press(4'd9, 4);
    s0 = strobes_seen;
    data = 4'd2; loadn = 1'b0; step(1);
    clr = 1'b1; step(1); clr = 1'b0; step(3);
    loadn = 1'b1; step(2);
    chk_digits("clr_edge", 0, 0, 0, 0);
    chk("clr_edge.strobes", strobes_seen - s0, 0);

    // async reset mid-qualification, key held across release
    press(4'd8, 4);
    chk_digits("pre_rst", 0, 0, 8, 1);
    data = 4'd6; loadn = 1'b0; step(1);
    #2 clrn = 1'b0;
    #1 chk_digits("async", 0, 0, 0, 0);
    step(1);
    clrn = 1'b1;
    step(4);
    loadn = 1'b1;
    step(2);
    chk_digits("repress", 0, 0, 6, 1);

    // randomized phase
    for (int i = 0; i < 3000; i++) begin
      step(1);
      if ($urandom_range(3) == 0) loadn = ~loadn;
      if (loadn) data = 4'($urandom_range(15));
      lock = ($urandom_range(7) == 0);
      clr  = ($urandom_range(39) == 0);
      clrn = ($urandom_range(299) != 0);
    end
    clrn = 1'b1; clr = 1'b0; loadn = 1'b1;
    step(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
